// File: rtl/mixer_bias_lo_seq_if.sv
// Control/status bundle between the mixer sequencer and its host/analog front end.
interface mixer_bias_lo_seq_if #(
  parameter int BIAS_W = 8,
  parameter int TRIM_W = 6,
  parameter int DIV_W  = 16
);
  logic              en;
  logic              recal;
  logic [BIAS_W-1:0] bias_tgt;
  logic [BIAS_W-1:0] ramp_step;
  logic [DIV_W-1:0]  lo_half;
  logic              cmp_gt;
  logic [BIAS_W-1:0] bias_code;
  logic [TRIM_W-1:0] trim_code;
  logic              lo_p;
  logic              lo_n;
  logic              ready;
  logic              cal_done;

  modport master (
    output en, recal, bias_tgt, ramp_step, lo_half, cmp_gt,
    input  bias_code, trim_code, lo_p, lo_n, ready, cal_done
  );

  modport slave (
    input  en, recal, bias_tgt, ramp_step, lo_half, cmp_gt,
    output bias_code, trim_code, lo_p, lo_n, ready, cal_done
  );
endinterface

// File: rtl/mixer_bias_lo_seq.sv
// Active-mixer bring-up sequencer: tail-bias ramp, settle, SAR offset trim,
// then dead-timed complementary LO drive. All outputs registered.
module mixer_bias_lo_seq #(
  parameter int BIAS_W     = 8,
  parameter int TRIM_W     = 6,
  parameter int DIV_W      = 16,
  parameter int RAMP_DIV   = 16,
  parameter int SETTLE_CYC = 1024,
  parameter int CAL_WAIT   = 64
) (
  input logic              clk,
  input logic              rst,
  mixer_bias_lo_seq_if.slave bus
);
  localparam int CNT_MAX = (RAMP_DIV > SETTLE_CYC)
                         ? ((RAMP_DIV > CAL_WAIT) ? RAMP_DIV : CAL_WAIT)
                         : ((SETTLE_CYC > CAL_WAIT) ? SETTLE_CYC : CAL_WAIT);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [CNT_W-1:0]  RAMP_LAST   = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CAL_LAST    = CNT_W'(CAL_WAIT - 1);
  localparam logic [TRIM_W-1:0] MID         = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [BIT_W-1:0]  MSB_IDX     = BIT_W'(TRIM_W - 1);

  typedef enum logic [2:0] {IDLE, RAMP_UP, SETTLE, CAL, RUN, RAMP_DN} state_t;

  state_t            st, st_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BIAS_W-1:0] tgt, tgt_nxt, bias, bias_nxt;
  logic [TRIM_W-1:0] trim, trim_nxt;
  logic [BIT_W-1:0]  bidx, bidx_nxt;
  logic [DIV_W-1:0]  half, half_nxt;
  logic [DIV_W:0]    ph, ph_nxt;
  logic              lo_p, lo_p_nxt, lo_n, lo_n_nxt;
  logic              ready, ready_nxt, done, done_nxt;

  logic [BIAS_W-1:0] step_eff, up_val, dn_val;
  logic [BIAS_W:0]   sum;
  logic [DIV_W-1:0]  lo_half_eff;
  logic [DIV_W:0]    half_ext, period_last, ph_inc;
  logic [TRIM_W-1:0] trial_bit, decided, next_bit;

  // Ramp arithmetic is one bit wider so a large step cannot wrap past the target.
  assign step_eff    = (bus.ramp_step == '0) ? BIAS_W'(1) : bus.ramp_step;
  assign sum         = {1'b0, bias} + {1'b0, step_eff};
  assign up_val      = (sum >= {1'b0, tgt}) ? tgt : sum[BIAS_W-1:0];
  assign dn_val      = (bias > step_eff) ? (bias - step_eff) : '0;
  assign lo_half_eff = (bus.lo_half < DIV_W'(2)) ? DIV_W'(2) : bus.lo_half;
  assign half_ext    = {1'b0, half};
  assign period_last = {half, 1'b0} - (DIV_W+1)'(1);
  assign ph_inc      = (ph == period_last) ? '0 : ph + (DIV_W+1)'(1);
  assign trial_bit   = TRIM_W'(1) << bidx;
  assign decided     = bus.cmp_gt ? (trim & ~trial_bit) : trim;
  assign next_bit    = TRIM_W'(1) << (bidx - BIT_W'(1));

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    bias_nxt  = bias;
    trim_nxt  = trim;
    bidx_nxt  = bidx;
    half_nxt  = half;
    ph_nxt    = ph;
    lo_p_nxt  = 1'b0;
    lo_n_nxt  = 1'b0;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (st != IDLE && st != RAMP_DN && !bus.en) begin
      st_nxt  = RAMP_DN;
      cnt_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          bias_nxt = '0;
          if (bus.en) begin
            st_nxt  = RAMP_UP;
            tgt_nxt = bus.bias_tgt;
            cnt_nxt = '0;
          end
        end
        RAMP_UP: begin
          if (bias == tgt) begin
            st_nxt  = SETTLE;
            cnt_nxt = '0;
          end else if (cnt == RAMP_LAST) begin
            bias_nxt = up_val;
            cnt_nxt  = '0;
          end else cnt_nxt = cnt + CNT_W'(1);
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            st_nxt   = CAL;
            cnt_nxt  = '0;
            trim_nxt = MID;
            bidx_nxt = MSB_IDX;
          end else cnt_nxt = cnt + CNT_W'(1);
        end
        CAL: begin
          if (cnt == CAL_LAST) begin
            cnt_nxt = '0;
            if (bidx == '0) begin
              // Last decision: the first RUN cycle already drives lo_p.
              trim_nxt  = decided;
              done_nxt  = 1'b1;
              st_nxt    = RUN;
              half_nxt  = lo_half_eff;
              ph_nxt    = '0;
              ready_nxt = 1'b1;
              lo_p_nxt  = 1'b1;
            end else begin
              trim_nxt = decided | next_bit;
              bidx_nxt = bidx - BIT_W'(1);
            end
          end else cnt_nxt = cnt + CNT_W'(1);
        end
        RUN: begin
          if (bus.recal) begin
            st_nxt   = CAL;
            cnt_nxt  = '0;
            trim_nxt = MID;
            bidx_nxt = MSB_IDX;
          end else begin
            ready_nxt = 1'b1;
            ph_nxt    = ph_inc;
            lo_p_nxt  = (ph_inc < half_ext - (DIV_W+1)'(1));
            lo_n_nxt  = (ph_inc >= half_ext) && (ph_inc < period_last);
          end
        end
        RAMP_DN: begin
          if (bias == '0) st_nxt = IDLE;
          else if (cnt == RAMP_LAST) begin
            bias_nxt = dn_val;
            cnt_nxt  = '0;
          end else cnt_nxt = cnt + CNT_W'(1);
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      tgt   <= '0;
      bias  <= '0;
      trim  <= MID;
      bidx  <= MSB_IDX;
      half  <= DIV_W'(2);
      ph    <= '0;
      lo_p  <= 1'b0;
      lo_n  <= 1'b0;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      tgt   <= tgt_nxt;
      bias  <= bias_nxt;
      trim  <= trim_nxt;
      bidx  <= bidx_nxt;
      half  <= half_nxt;
      ph    <= ph_nxt;
      lo_p  <= lo_p_nxt;
      lo_n  <= lo_n_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
    end
  end

  assign bus.bias_code = bias;
  assign bus.trim_code = trim;
  assign bus.lo_p      = lo_p;
  assign bus.lo_n      = lo_n;
  assign bus.ready     = ready;
  assign bus.cal_done  = done;
endmodule
